// File: rtl/systolic_skew_feeder.sv
// Skew feeder for an output-stationary systolic array.
// Accepts aligned activation/weight beats over valid/ready and re-times them
// into a diagonal wavefront: lane k carries its element k+1 cycles after accept.
// After the last beat of a tile the feeder stalls input until the tail has
// left the deepest lane, then pulses done.

// One lane of the skew: a DEPTH-stage register chain.
module skew_lane #(
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] sr [DEPTH];

    // Shift the lane one stage per cycle; bubbles arrive as zeros on din.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];
endmodule

module systolic_skew_feeder #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [ROWS*DW-1:0]   in_a,
    input  logic [COLS*DW-1:0]   in_w,
    output logic [ROWS*DW-1:0]   out_a,
    output logic [COLS*DW-1:0]   out_w,
    output logic                 fire,
    output logic                 busy,
    output logic                 done,
    output logic [CNTW-1:0]      beat_cnt
);
    // Deepest lane decides how long the tail takes to drain.
    localparam int N  = (ROWS > COLS) ? ROWS : COLS;
    localparam int FW = $clog2(N);
    // FLUSH lasts N-1 cycles: counter runs N-2 down to 0.
    localparam logic [FW-1:0] FLUSH_INIT = FW'(N - 2);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [FW-1:0] flush_cnt;
    logic          accept;

    assign accept = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last ? FLUSH : STREAM;
            STREAM:  if (accept && in_last) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and status; in_ready is forced low while reset is held.
    always_comb begin
        in_ready = !rst && (state != FLUSH);
        busy     = (state != IDLE);
    end

    // Flush counter: load on FLUSH entry, count down while draining.
    always_ff @(posedge clk) begin
        if (rst)
            flush_cnt <= '0;
        else if (state != FLUSH && state_nxt == FLUSH)
            flush_cnt <= FLUSH_INIT;
        else if (state == FLUSH && flush_cnt != '0)
            flush_cnt <= flush_cnt - 1'b1;
    end

    // done lands in the IDLE-entry cycle, when the deepest lane shows the tail.
    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else     done <= (state == FLUSH) && (flush_cnt == '0);
    end

    // fire marks a real beat on lane 0, aligned with the depth-1 lane registers.
    always_ff @(posedge clk) begin
        if (rst) fire <= 1'b0;
        else     fire <= accept;
    end

    // Beat counter: restarts at 1 on a tile's first beat, saturates, holds after done.
    always_ff @(posedge clk) begin
        if (rst)
            beat_cnt <= '0;
        else if (accept) begin
            if (state == IDLE)          beat_cnt <= CNTW'(1);
            else if (beat_cnt != '1)    beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Lane r of each edge is delayed r+1 cycles; non-accept cycles inject zero.
    for (genvar r = 0; r < ROWS; r++) begin : g_a
        skew_lane #(.DW(DW), .DEPTH(r + 1)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .din  (accept ? in_a[r*DW +: DW] : {DW{1'b0}}),
            .dout (out_a[r*DW +: DW])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_w
        skew_lane #(.DW(DW), .DEPTH(c + 1)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .din  (accept ? in_w[c*DW +: DW] : {DW{1'b0}}),
            .dout (out_w[c*DW +: DW])
        );
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (4x4, 8-bit elements).
// Each scenario drives one cycle at a time and checks every output at the
// falling edge against a small schedule model plus hand-derived status masks.
module tb_systolic_skew_feeder;
    localparam int ROWS = 4, COLS = 4, DW = 8, CNTW = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0, in_last = 1'b0;
    logic                in_ready;
    logic [ROWS*DW-1:0]  in_a = '0;
    logic [COLS*DW-1:0]  in_w = '0;
    logic [ROWS*DW-1:0]  out_a;
    logic [COLS*DW-1:0]  out_w;
    logic                fire, busy, done;
    logic [CNTW-1:0]     beat_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    // Beats the bench expects to be accepted, indexed by the cycle they were driven.
    logic [31:0] sa [32];
    logic [31:0] sw [32];
    logic        sv [32];

    systolic_skew_feeder #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_a(in_a), .in_w(in_w), .out_a(out_a), .out_w(out_w),
        .fire(fire), .busy(busy), .done(done), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // Element r of beat k is k+1+r.
    function automatic logic [31:0] beat(int k);
        logic [31:0] v;
        for (int r = 0; r < 4; r++) v[r*8 +: 8] = 8'(k + 1 + r);
        return v;
    endfunction

    function automatic logic [15:0] rng(int lo, int hi);
        logic [15:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_a(int c);
        logic [31:0] e = '0;
        for (int r = 0; r < 4; r++)
            if (c - 1 - r >= 0 && sv[c-1-r]) e[r*8 +: 8] = sa[c-1-r][r*8 +: 8];
        return e;
    endfunction

    function automatic logic [31:0] exp_w(int c);
        logic [31:0] e = '0;
        for (int r = 0; r < 4; r++)
            if (c - 1 - r >= 0 && sv[c-1-r]) e[r*8 +: 8] = sw[c-1-r][r*8 +: 8];
        return e;
    endfunction

    function automatic logic exp_fire(int c);
        return (c >= 1) ? sv[c-1] : 1'b0;
    endfunction

    task automatic clr();
        for (int i = 0; i < 32; i++) begin sv[i] = 1'b0; sa[i] = '0; sw[i] = '0; end
    endtask

    task automatic drv(int c, logic v, logic l, logic [31:0] a, logic [31:0] w, logic acc);
        in_valid = v; in_last = l; in_a = a; in_w = w;
        if (acc) begin sv[c] = 1'b1; sa[c] = a; sw[c] = w; end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (out_a !== '0)     begin n_fail++; $display("FAIL reset out_a got=%h want=0", out_a); end
        n_cmp++; if (out_w !== '0)     begin n_fail++; $display("FAIL reset out_w got=%h want=0", out_w); end
        n_cmp++; if (fire !== 1'b0)    begin n_fail++; $display("FAIL reset fire got=%b want=0", fire); end
        n_cmp++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset done got=%b want=0", done); end
        n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset busy got=%b want=0", busy); end
        n_cmp++; if (beat_cnt !== '0)  begin n_fail++; $display("FAIL reset beat_cnt got=%0d want=0", beat_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
    endtask

    // Four back-to-back beats, last on beat 3.
    task automatic test_basic(string tag);
        logic [15:0] eb, er, ed; int bc[16];
        eb = rng(1, 6); er = ~rng(4, 6); ed = rng(7, 7);
        bc = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        clr();
        for (int c = 0; c < 10; c++) begin
            if (c < 4) drv(c, 1'b1, c == 3, beat(c), beat(c), 1'b1);
            else       drv(c, 1'b0, 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            n_cmp++; if (out_a !== exp_a(c)) begin n_fail++; $display("FAIL %s out_a c%0d got=%h want=%h", tag, c, out_a, exp_a(c)); end
            n_cmp++; if (out_w !== exp_w(c)) begin n_fail++; $display("FAIL %s out_w c%0d got=%h want=%h", tag, c, out_w, exp_w(c)); end
            n_cmp++; if (fire !== exp_fire(c)) begin n_fail++; $display("FAIL %s fire c%0d got=%b want=%b", tag, c, fire, exp_fire(c)); end
            n_cmp++; if (in_ready !== er[c]) begin n_fail++; $display("FAIL %s in_ready c%0d got=%b want=%b", tag, c, in_ready, er[c]); end
            n_cmp++; if (busy !== eb[c]) begin n_fail++; $display("FAIL %s busy c%0d got=%b want=%b", tag, c, busy, eb[c]); end
            n_cmp++; if (done !== ed[c]) begin n_fail++; $display("FAIL %s done c%0d got=%b want=%b", tag, c, done, ed[c]); end
            n_cmp++; if (beat_cnt !== CNTW'(bc[c])) begin n_fail++; $display("FAIL %s beat_cnt c%0d got=%0d want=%0d", tag, c, beat_cnt, bc[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Same tile with a bubble in cycle 1; everything after slips one cycle.
    task automatic test_bubble();
        logic [15:0] eb, er, ed; int bc[16];
        eb = rng(1, 7); er = ~rng(5, 7); ed = rng(8, 8);
        bc = '{4, 1, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        clr();
        for (int c = 0; c < 11; c++) begin
            if (c == 0)     drv(c, 1'b1, 1'b0, beat(0), beat(0), 1'b1);
            else if (c == 1) drv(c, 1'b0, 1'b0, '0, '0, 1'b0);
            else if (c < 5) drv(c, 1'b1, c == 4, beat(c - 1), beat(c - 1), 1'b1);
            else            drv(c, 1'b0, 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            n_cmp++; if (out_a !== exp_a(c)) begin n_fail++; $display("FAIL bubble out_a c%0d got=%h want=%h", c, out_a, exp_a(c)); end
            n_cmp++; if (out_w !== exp_w(c)) begin n_fail++; $display("FAIL bubble out_w c%0d got=%h want=%h", c, out_w, exp_w(c)); end
            n_cmp++; if (fire !== exp_fire(c)) begin n_fail++; $display("FAIL bubble fire c%0d got=%b want=%b", c, fire, exp_fire(c)); end
            n_cmp++; if (in_ready !== er[c]) begin n_fail++; $display("FAIL bubble in_ready c%0d got=%b want=%b", c, in_ready, er[c]); end
            n_cmp++; if (busy !== eb[c]) begin n_fail++; $display("FAIL bubble busy c%0d got=%b want=%b", c, busy, eb[c]); end
            n_cmp++; if (done !== ed[c]) begin n_fail++; $display("FAIL bubble done c%0d got=%b want=%b", c, done, ed[c]); end
            n_cmp++; if (beat_cnt !== CNTW'(bc[c])) begin n_fail++; $display("FAIL bubble beat_cnt c%0d got=%0d want=%0d", c, beat_cnt, bc[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Single-beat tile of all 9s goes straight to FLUSH.
    task automatic test_single();
        logic [15:0] eb, er, ed; int bc[16];
        eb = rng(1, 3); er = ~rng(1, 3); ed = rng(4, 4);
        bc = '{4, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        clr();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) drv(c, 1'b1, 1'b1, {4{8'h09}}, {4{8'h09}}, 1'b1);
            else        drv(c, 1'b0, 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            n_cmp++; if (out_a !== exp_a(c)) begin n_fail++; $display("FAIL single out_a c%0d got=%h want=%h", c, out_a, exp_a(c)); end
            n_cmp++; if (out_w !== exp_w(c)) begin n_fail++; $display("FAIL single out_w c%0d got=%h want=%h", c, out_w, exp_w(c)); end
            n_cmp++; if (fire !== exp_fire(c)) begin n_fail++; $display("FAIL single fire c%0d got=%b want=%b", c, fire, exp_fire(c)); end
            n_cmp++; if (in_ready !== er[c]) begin n_fail++; $display("FAIL single in_ready c%0d got=%b want=%b", c, in_ready, er[c]); end
            n_cmp++; if (busy !== eb[c]) begin n_fail++; $display("FAIL single busy c%0d got=%b want=%b", c, busy, eb[c]); end
            n_cmp++; if (done !== ed[c]) begin n_fail++; $display("FAIL single done c%0d got=%b want=%b", c, done, ed[c]); end
            n_cmp++; if (beat_cnt !== CNTW'(bc[c])) begin n_fail++; $display("FAIL single beat_cnt c%0d got=%0d want=%0d", c, beat_cnt, bc[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Single-beat tile, then a 2-beat tile offered in the done cycle (cycle 4).
    task automatic test_back_to_back();
        logic [15:0] eb, er, ed; int bc[16];
        eb = rng(1, 3) | rng(5, 8); er = ~(rng(1, 3) | rng(6, 8)); ed = rng(4, 4) | rng(9, 9);
        bc = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        clr();
        for (int c = 0; c < 12; c++) begin
            if (c == 0)      drv(c, 1'b1, 1'b1, {4{8'h09}}, {4{8'h09}}, 1'b1);
            else if (c == 4) drv(c, 1'b1, 1'b0, beat(8'h1f), beat(8'h3f), 1'b1);
            else if (c == 5) drv(c, 1'b1, 1'b1, beat(8'h2f), beat(8'h4f), 1'b1);
            else             drv(c, 1'b0, 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            n_cmp++; if (out_a !== exp_a(c)) begin n_fail++; $display("FAIL b2b out_a c%0d got=%h want=%h", c, out_a, exp_a(c)); end
            n_cmp++; if (out_w !== exp_w(c)) begin n_fail++; $display("FAIL b2b out_w c%0d got=%h want=%h", c, out_w, exp_w(c)); end
            n_cmp++; if (fire !== exp_fire(c)) begin n_fail++; $display("FAIL b2b fire c%0d got=%b want=%b", c, fire, exp_fire(c)); end
            n_cmp++; if (in_ready !== er[c]) begin n_fail++; $display("FAIL b2b in_ready c%0d got=%b want=%b", c, in_ready, er[c]); end
            n_cmp++; if (busy !== eb[c]) begin n_fail++; $display("FAIL b2b busy c%0d got=%b want=%b", c, busy, eb[c]); end
            n_cmp++; if (done !== ed[c]) begin n_fail++; $display("FAIL b2b done c%0d got=%b want=%b", c, done, ed[c]); end
            n_cmp++; if (beat_cnt !== CNTW'(bc[c])) begin n_fail++; $display("FAIL b2b beat_cnt c%0d got=%0d want=%0d", c, beat_cnt, bc[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Two-beat tile; during FLUSH in_valid/in_last stay high with 0xFF data.
    task automatic test_flush_hold();
        logic [15:0] eb, er, ed; int bc[16];
        eb = rng(1, 4); er = ~rng(2, 4); ed = rng(5, 5);
        bc = '{2, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        clr();
        for (int c = 0; c < 9; c++) begin
            if (c < 2)      drv(c, 1'b1, c == 1, beat(c), beat(c), 1'b1);
            else if (c < 5) drv(c, 1'b1, 1'b1, {4{8'hff}}, {4{8'hff}}, 1'b0);
            else            drv(c, 1'b0, 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            n_cmp++; if (out_a !== exp_a(c)) begin n_fail++; $display("FAIL fhold out_a c%0d got=%h want=%h", c, out_a, exp_a(c)); end
            n_cmp++; if (out_w !== exp_w(c)) begin n_fail++; $display("FAIL fhold out_w c%0d got=%h want=%h", c, out_w, exp_w(c)); end
            n_cmp++; if (fire !== exp_fire(c)) begin n_fail++; $display("FAIL fhold fire c%0d got=%b want=%b", c, fire, exp_fire(c)); end
            n_cmp++; if (in_ready !== er[c]) begin n_fail++; $display("FAIL fhold in_ready c%0d got=%b want=%b", c, in_ready, er[c]); end
            n_cmp++; if (busy !== eb[c]) begin n_fail++; $display("FAIL fhold busy c%0d got=%b want=%b", c, busy, eb[c]); end
            n_cmp++; if (done !== ed[c]) begin n_fail++; $display("FAIL fhold done c%0d got=%b want=%b", c, done, ed[c]); end
            n_cmp++; if (beat_cnt !== CNTW'(bc[c])) begin n_fail++; $display("FAIL fhold beat_cnt c%0d got=%0d want=%0d", c, beat_cnt, bc[c]); end
            @(posedge clk); #1;
        end
    endtask

    // Two beats, then rst held through cycle 2; pipeline must be empty afterwards.
    task automatic test_reset_mid();
        logic [15:0] eb, er, ed; int bc[16];
        eb = rng(1, 2); er = ~rng(2, 2); ed = '0;
        bc = '{2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        clr();
        for (int c = 0; c < 8; c++) begin
            rst = (c == 2);
            if (c < 2)       drv(c, 1'b1, 1'b0, beat(c), beat(c), 1'b1);
            else if (c == 2) drv(c, 1'b1, 1'b0, beat(2), beat(2), 1'b0);
            else             drv(c, 1'b0, 1'b0, '0, '0, 1'b0);
            @(negedge clk);
            n_cmp++; if (out_a !== exp_a(c)) begin n_fail++; $display("FAIL rstmid out_a c%0d got=%h want=%h", c, out_a, exp_a(c)); end
            n_cmp++; if (out_w !== exp_w(c)) begin n_fail++; $display("FAIL rstmid out_w c%0d got=%h want=%h", c, out_w, exp_w(c)); end
            n_cmp++; if (fire !== exp_fire(c)) begin n_fail++; $display("FAIL rstmid fire c%0d got=%b want=%b", c, fire, exp_fire(c)); end
            n_cmp++; if (in_ready !== er[c]) begin n_fail++; $display("FAIL rstmid in_ready c%0d got=%b want=%b", c, in_ready, er[c]); end
            n_cmp++; if (busy !== eb[c]) begin n_fail++; $display("FAIL rstmid busy c%0d got=%b want=%b", c, busy, eb[c]); end
            n_cmp++; if (done !== ed[c]) begin n_fail++; $display("FAIL rstmid done c%0d got=%b want=%b", c, done, ed[c]); end
            n_cmp++; if (beat_cnt !== CNTW'(bc[c])) begin n_fail++; $display("FAIL rstmid beat_cnt c%0d got=%0d want=%0d", c, beat_cnt, bc[c]); end
            // Reset at the end of cycle 2 flushes everything in flight.
            if (c == 2) clr();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_basic("basic");
        test_bubble();
        test_single();
        test_back_to_back();
        test_flush_hold();
        test_reset_mid();
        test_basic("basic_after_rst");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
